alu_arbiter: RTL and testbench

Shares one registered ALU (single-cycle latency, updates only when its clock enable is high) between two requesters. Each requester has a valid/ready operation channel and a valid/ready result channel. The block arbitrates between requesters, drives the ALU operands and clock enable, captures the result, and returns it to the requester that issued the operation. It sits between the CPU issue logic and the ALU.

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester operation/result channels plus the shared ALU port of alu_arbiter.
// The arbiter uses the slave modport; requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int FN_W  = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [FN_W-1:0]  req0_fn;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_res;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [FN_W-1:0]  req1_fn;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_res;

    logic             alu_clk_en;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [FN_W-1:0]  alu_fn;
    logic [WIDTH-1:0] alu_res;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fn, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_fn, rsp1_ready,
        input  alu_res,
        output req0_ready, rsp0_valid, rsp0_res,
        output req1_ready, rsp1_valid, rsp1_res,
        output alu_clk_en, alu_a, alu_b, alu_fn,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fn, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_fn, rsp1_ready,
        output alu_res,
        input  req0_ready, rsp0_valid, rsp0_res,
        input  req1_ready, rsp1_valid, rsp1_res,
        input  alu_clk_en, alu_a, alu_b, alu_fn,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one registered single-cycle ALU between two requesters, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FN_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic             busy_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [WIDTH-1:0] rsp0_res_q;
    logic [WIDTH-1:0] rsp1_res_q;

    logic             accept;
    logic             winner;
    logic             owner_ready;

`ifdef ALU_ARB_RR_EN
    logic             last_grant;
`endif

    // winner is only meaningful while at least one requester is valid
    always_comb begin
        winner = !bus.req0_valid;
`ifdef ALU_ARB_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            winner = !last_grant;
        end
`endif
    end

    assign accept      = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.req0_ready = accept && !winner;
    assign bus.req1_ready = accept && winner;
    assign bus.alu_clk_en = accept;
    assign bus.alu_a      = !accept ? '0 : (winner ? bus.req1_a  : bus.req0_a);
    assign bus.alu_b      = !accept ? '0 : (winner ? bus.req1_b  : bus.req0_b);
    assign bus.alu_fn     = !accept ? '0 : (winner ? bus.req1_fn : bus.req0_fn);

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_res   = rsp0_res_q;
    assign bus.rsp1_res   = rsp1_res_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp1_res_q   <= '0;
`ifdef ALU_ARB_RR_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= winner;
                        busy_q <= 1'b1;
                        state  <= EXEC;
`ifdef ALU_ARB_RR_EN
                        last_grant <= winner;
`endif
                    end
                end
                // ALU registered the operands on the accept edge; its output is valid now
                EXEC: begin
                    if (owner) begin
                        rsp1_res_q   <= bus.alu_res;
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rsp0_res_q   <= bus.alu_res;
                        rsp0_valid_q <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU model.
// Grant-order expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int FN_W  = 4;

    localparam logic [3:0] FN_ADD   = 4'b0001;
    localparam logic [3:0] FN_SUB   = 4'b0010;
    localparam logic [3:0] FN_MUL   = 4'b0011;
    localparam logic [3:0] FN_DIV   = 4'b0100;
    localparam logic [3:0] FN_XOR   = 4'b0101;
    localparam logic [3:0] FN_CMPLT = 4'b0110;
    localparam logic [3:0] FN_UNDEF = 4'b1111;

    typedef struct {
        string       name;
        int          id;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    alu_arbiter_if #(.WIDTH(WIDTH), .FN_W(FN_W)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .FN_W(FN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: DIV is unimplemented and, like undefined codes, returns 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_res <= '0;
        end else if (bus.alu_clk_en) begin
            case (bus.alu_fn)
                FN_ADD:   bus.alu_res <= bus.alu_a + bus.alu_b;
                FN_SUB:   bus.alu_res <= bus.alu_a - bus.alu_b;
                FN_MUL:   bus.alu_res <= bus.alu_a * bus.alu_b;
                FN_XOR:   bus.alu_res <= bus.alu_a ^ bus.alu_b;
                FN_CMPLT: bus.alu_res <= {31'd0, bus.alu_a < bus.alu_b};
                default:  bus.alu_res <= '0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] fn);
        if (id == 0) begin
            bus.req0_valid = valid;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_fn    = fn;
        end else begin
            bus.req1_valid = valid;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_fn    = fn;
        end
    endtask

    function automatic logic ready_of(input int id);
        return (id == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rsp_valid_of(input int id);
        return (id == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    function automatic logic [31:0] rsp_res_of(input int id);
        return (id == 0) ? bus.rsp0_res : bus.rsp1_res;
    endfunction

    // One isolated operation: accept at T, EXEC at T+1, response at T+2, handshake there
    task automatic doOp(input vec_t v);
        @(negedge clk);
        applyStimulus(v.id, 1'b1, v.a, v.b, v.fn);
        #1;
        checkOutput({v.name, "_ready"}, {31'd0, ready_of(v.id)}, 32'd1);
        checkOutput({v.name, "_other_ready"}, {31'd0, ready_of(1 - v.id)}, 32'd0);
        checkOutput({v.name, "_clk_en"}, {31'd0, bus.alu_clk_en}, 32'd1);
        checkOutput({v.name, "_alu_a"}, bus.alu_a, v.a);
        checkOutput({v.name, "_alu_fn"}, {28'd0, bus.alu_fn}, {28'd0, v.fn});
        @(negedge clk);
        applyStimulus(v.id, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
        #1;
        checkOutput({v.name, "_exec_busy"}, {31'd0, bus.busy}, 32'd1);
        checkOutput({v.name, "_exec_valid"}, {31'd0, rsp_valid_of(v.id)}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput({v.name, "_rsp_valid"}, {31'd0, rsp_valid_of(v.id)}, 32'd1);
        checkOutput({v.name, "_other_valid"}, {31'd0, rsp_valid_of(1 - v.id)}, 32'd0);
        checkOutput({v.name, "_rsp_res"}, rsp_res_of(v.id), v.exp);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #1;
        checkOutput({v.name, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({v.name, "_done_valid"}, {31'd0, rsp_valid_of(v.id)}, 32'd0);
    endtask

    initial begin
        vec_t  vecs[8];
        logic  grant;
        logic  found;
        logic  exp_grant[4];
        logic  seen_valid;
        vec_t  after_reset;

        vecs[0] = '{"add_5_7",     0, FN_ADD,   32'd5,    32'd7,    32'd12};
        vecs[1] = '{"sub_10_3",    1, FN_SUB,   32'd10,   32'd3,    32'd7};
        vecs[2] = '{"mul_6_7",     0, FN_MUL,   32'd6,    32'd7,    32'd42};
        vecs[3] = '{"xor_f0_ff",   1, FN_XOR,   32'hF0,   32'hFF,   32'h0F};
        vecs[4] = '{"cmplt_3_9",   0, FN_CMPLT, 32'd3,    32'd9,    32'd1};
        vecs[5] = '{"cmplt_9_3",   1, FN_CMPLT, 32'd9,    32'd3,    32'd0};
        vecs[6] = '{"div_20_4",    0, FN_DIV,   32'd20,   32'd4,    32'd0};
        vecs[7] = '{"undef_fn",    1, FN_UNDEF, 32'd5,    32'd7,    32'd0};
        after_reset = '{"add_2_2", 0, FN_ADD, 32'd2, 32'd2, 32'd4};

`ifdef ALU_ARB_RR_EN
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        applyStimulus(0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        checkOutput("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        checkOutput("rst_rsp0_res", bus.rsp0_res, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_clk_en", {31'd0, bus.alu_clk_en}, 32'd0);
        checkOutput("rst_alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of isolated operations on both requesters
        for (int i = 0; i < 8; i++) begin
            doOp(vecs[i]);
        end

        // Contention with fixed priority reset state: req0 SUB wins, req1 MUL follows
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'd10, 32'd3, FN_SUB);
        applyStimulus(1, 1'b1, 32'd6, 32'd7, FN_MUL);
        #1;
        checkOutput("both_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        checkOutput("both_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        applyStimulus(0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("both_exec_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("both_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        checkOutput("both_rsp0_res", bus.rsp0_res, 32'd7);
        checkOutput("both_rsp1_quiet", {31'd0, bus.rsp1_valid}, 32'd0);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        #1;
        checkOutput("both_req1_accept", {31'd0, bus.req1_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        checkOutput("both_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        checkOutput("both_rsp1_res", bus.rsp1_res, 32'd42);
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        bus.rsp1_ready = 1'b0;

        // Backpressure on requester 1 with requester 0 knocking
        @(negedge clk);
        applyStimulus(1, 1'b1, 32'hF0, 32'hFF, FN_XOR);
        @(negedge clk);
        applyStimulus(1, 1'b0, '0, '0, '0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'd1, 32'd1, FN_ADD);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("bp_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
            checkOutput("bp_rsp1_res", bus.rsp1_res, 32'h0F);
            checkOutput("bp_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
            checkOutput("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
            checkOutput("bp_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        applyStimulus(0, 1'b0, '0, '0, '0);
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        bus.rsp1_ready = 1'b0;
        #1;
        checkOutput("bp_release_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("bp_release_valid", {31'd0, bus.rsp1_valid}, 32'd0);

        // Reset asserted while req0 CMPLT is executing
        @(negedge clk);
        applyStimulus(0, 1'b1, 32'd3, 32'd9, FN_CMPLT);
        @(negedge clk);
        applyStimulus(0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        checkOutput("midrst_rsp0_res", bus.rsp0_res, 32'd0);
        checkOutput("midrst_rsp1_res", bus.rsp1_res, 32'd0);
        checkOutput("midrst_clk_en", {31'd0, bus.alu_clk_en}, 32'd0);
        checkOutput("midrst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.rsp0_valid || bus.busy) seen_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("midrst_no_rsp", {31'd0, seen_valid}, 32'd0);
        doOp(after_reset);

        // Continuous contention: grant order across four operations from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 32'd1, 32'd1, FN_ADD);
        applyStimulus(1, 1'b1, 32'd1, 32'd1, FN_ADD);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            grant = 1'b0;
            for (int cyc = 0; cyc < 10 && !found; cyc++) begin
                #1;
                if (bus.req0_ready || bus.req1_ready) begin
                    grant = bus.req1_ready;
                    found = 1'b1;
                end
                @(negedge clk);
            end
            checkOutput("rr_grant_found", {31'd0, found}, 32'd1);
            checkOutput("rr_grant_id", {31'd0, grant}, {31'd0, exp_grant[k]});
        end
        applyStimulus(0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rr_drain_busy", {31'd0, bus.busy}, 32'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
